mk_bit_serializer: RTL and testbench

Parallel-to-serial front stage that feeds the single-bit input of the mkM4 hierarchy through `d_in`, which reaches mkM3, mkM2 and mkM1. It accepts WIDTH-bit words over a valid/ready handshake and buffers one word in a holding register. It shifts each word out one bit per clock on `ser_out`, with per-bit valid and last-bit markers. Back-to-back words stream with no idle cycle between them.

---
 rtl/mk_bit_serializer.sv | 91 +++++++++
 tb/tb_mk_bit_serializer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mk_bit_serializer.sv
// Parallel-to-serial front stage: one-word holding register feeding a shift register,
// emitting one bit per clock with per-bit valid and last-bit markers.
module mk_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic [15:0]      word_cnt
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pend;
    logic             pend_valid;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             at_last;
    logic             ld;

    assign accept  = din_valid && !pend_valid;
    assign at_last = (state == SHIFT) && (cnt == LAST_IDX);
    assign ld      = pend_valid && ((state == IDLE) || at_last);
    assign sh_next = LSB_FIRST ? {1'b0, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], 1'b0};

    // Every output decodes from state alone, so reset clears them immediately
    // and nothing on the input side reaches them combinationally.
    assign din_ready = !pend_valid;
    assign ser_valid = (state == SHIFT);
    assign ser_last  = at_last;
    assign ser_out   = (state == SHIFT) && (LSB_FIRST ? sh[0] : sh[WIDTH-1]);

    // NOTE: pend is pure data qualified by pend_valid, so it carries no reset;
    // keeping it out of the reset block avoids a reset-dependent enable on it.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend <= din;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every branch
    // below sees the pre-edge values of state, cnt and pend_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            sh         <= '0;
            cnt        <= '0;
            word_cnt   <= 16'd0;
        end else begin
            if (accept) begin
                pend_valid <= 1'b1;
            end

            if (state == SHIFT) begin
                if (cnt != LAST_IDX) begin
                    sh  <= sh_next;
                    cnt <= cnt + 1'b1;
                end else begin
                    word_cnt <= word_cnt + 16'd1;
                    state    <= IDLE;
                end
            end

            // A load overrides the end-of-word return to IDLE; accept and load
            // never coincide because they need opposite pend_valid values.
            if (ld) begin
                sh         <= pend;
                pend_valid <= 1'b0;
                cnt        <= '0;
                state      <= SHIFT;
            end
        end
    end

endmodule

// File: tb/tb_mk_bit_serializer.sv
// Self-checking bench for mk_bit_serializer: an LSB-first and an MSB-first instance
// share one stimulus stream; expected serial sequences are hand-computed per word.
module tb_mk_bit_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;

    logic        ready_l, out_l, valid_l, last_l;
    logic [15:0] wc_l;
    logic        ready_m, out_m, valid_m, last_m;
    logic [15:0] wc_m;

    int n_cmp  = 0;
    int n_fail = 0;

    // seq_* lists the bits in transmit order, leftmost character sent first.
    typedef struct {
        logic [7:0] word;
        logic [7:0] seq_lsb;
        logic [7:0] seq_msb;
    } vec_t;

    vec_t vecs [8];

    mk_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (ready_l),
        .ser_out   (out_l),
        .ser_valid (valid_l),
        .ser_last  (last_l),
        .word_cnt  (wc_l)
    );

    mk_bit_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (ready_m),
        .ser_out   (out_m),
        .ser_valid (valid_m),
        .ser_last  (last_m),
        .word_cnt  (wc_m)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [15:0] exp_cnt);
        check({tag, "_valid_l"}, 32'(valid_l), 32'(0));
        check({tag, "_valid_m"}, 32'(valid_m), 32'(0));
        check({tag, "_last_l"},  32'(last_l),  32'(0));
        check({tag, "_last_m"},  32'(last_m),  32'(0));
        check({tag, "_out_l"},   32'(out_l),   32'(0));
        check({tag, "_out_m"},   32'(out_m),   32'(0));
        check({tag, "_ready_l"}, 32'(ready_l), 32'(1));
        check({tag, "_ready_m"}, 32'(ready_m), 32'(1));
        check({tag, "_wcnt_l"},  32'(wc_l),    32'(exp_cnt));
        check({tag, "_wcnt_m"},  32'(wc_m),    32'(exp_cnt));
    endtask

    task automatic check_bit(input string tag, input int i, input int b);
        string p;
        p = $sformatf("%s_w%0d_b%0d", tag, i, b);
        check({p, "_valid_l"}, 32'(valid_l), 32'(1));
        check({p, "_valid_m"}, 32'(valid_m), 32'(1));
        check({p, "_out_l"},   32'(out_l),   32'(vecs[i].seq_lsb[7-b]));
        check({p, "_out_m"},   32'(out_m),   32'(vecs[i].seq_msb[7-b]));
        check({p, "_last_l"},  32'(last_l),  32'(b == 7));
        check({p, "_last_m"},  32'(last_m),  32'(b == 7));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int bad;
        bit got_ready;

        vecs[0] = '{8'hA5, 8'b10100101, 8'b10100101};
        vecs[1] = '{8'h81, 8'b10000001, 8'b10000001};
        vecs[2] = '{8'h01, 8'b10000000, 8'b00000001};
        vecs[3] = '{8'hFF, 8'b11111111, 8'b11111111};
        vecs[4] = '{8'h3C, 8'b00111100, 8'b00111100};
        vecs[5] = '{8'h12, 8'b01001000, 8'b00010010};
        vecs[6] = '{8'hF0, 8'b00001111, 8'b11110000};
        vecs[7] = '{8'h6B, 8'b11010110, 8'b01101011};

        rst       = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset", 16'd0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("after_reset", 16'd0);

        // Isolated words: exact latency, ready recovery and return to IDLE.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            din       = vecs[i].word;
            din_valid = 1'b1;
            @(negedge clk);
            din_valid = 1'b0;
            check($sformatf("single_w%0d_ready_busy", i), 32'(ready_l), 32'(0));
            check($sformatf("single_w%0d_valid_wait", i), 32'(valid_l), 32'(0));
            @(negedge clk);
            check($sformatf("single_w%0d_ready_back", i), 32'(ready_l), 32'(1));
            for (int b = 0; b < 8; b++) begin
                check_bit("single", i, b);
                @(negedge clk);
            end
            check_idle($sformatf("single_w%0d_done", i), 16'(i + 1));
        end

        // Streaming with din_valid held high; din carries junk whenever ready is low.
        fork
            begin : drv
                for (int i = 0; i < 8; i++) begin
                    got_ready = 1'b0;
                    for (int t = 0; t < 40 && !got_ready; t++) begin
                        @(negedge clk);
                        din_valid = 1'b1;
                        if (ready_l) begin
                            din       = vecs[i].word;
                            got_ready = 1'b1;
                        end else begin
                            din = 8'($urandom);
                        end
                    end
                    check($sformatf("stream_accept_w%0d", i), 32'(got_ready), 32'(1));
                end
                @(negedge clk);
                din_valid = 1'b0;
            end
            begin : mon
                for (int t = 0; t < 20 && !valid_l; t++) @(negedge clk);
                check("stream_start", 32'(valid_l), 32'(1));
                for (int i = 0; i < 8; i++) begin
                    for (int b = 0; b < 8; b++) begin
                        check_bit("stream", i, b);
                        @(negedge clk);
                    end
                end
                check_idle("stream_done", 16'd16);
            end
        join

        // Reset in the middle of 8'hF0 with 8'h55 already buffered.
        @(negedge clk);
        din       = vecs[6].word;
        din_valid = 1'b1;
        @(negedge clk);
        din = 8'h55;
        @(negedge clk);
        check("rstmid_buffer_ready", 32'(ready_l), 32'(1));
        check_bit("rstmid", 6, 0);
        @(negedge clk);
        din_valid = 1'b0;
        check_bit("rstmid", 6, 1);
        @(negedge clk);
        check_bit("rstmid", 6, 2);
        @(negedge clk);
        check_bit("rstmid", 6, 3);
        check("rstmid_pend_full", 32'(ready_l), 32'(0));
        #2 rst = 1'b1;
        #1 check_idle("rstmid_async", 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (valid_l || valid_m || out_l || out_m) bad++;
        end
        check("rstmid_quiet_20", 32'(bad), 32'(0));
        check_idle("rstmid_after", 16'd0);

        // Counter wrap: preset the counters just below the wrap point.
        @(negedge clk);
        force u_lsb.word_cnt = 16'hFFFF;
        force u_msb.word_cnt = 16'hFFFF;
        @(negedge clk);
        release u_lsb.word_cnt;
        release u_msb.word_cnt;
        @(negedge clk);
        din       = vecs[2].word;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            check_bit("wrap", 2, b);
            @(negedge clk);
        end
        check_idle("wrap_done", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
